tmr_scrub_ctrl: RTL and testbench

TMR_SCRUB_CTRL -- requirements
Module: tmr_scrub_ctrl

---
 rtl/tmr_scrub_ctrl.sv | 146 ++++++++++++++
 tb/tb_tmr_scrub_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_scrub_ctrl.sv
// Scrubber for triple-modular-redundant memory: walks addresses 0..last_addr,
// majority-votes the three copies, rewrites correctable words, counts outcomes.
module tmr_scrub_ctrl #(
    parameter int DATA_LEN = 16,
    parameter int ADDR_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     last_addr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_rd_en,
    input  logic [3*DATA_LEN-1:0] mem_rdata,
    output logic                  mem_wr_en,
    output logic [3*DATA_LEN-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           corr_cnt,
    output logic [15:0]           uncorr_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CHECK = 3'd2,
        WRITE = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   addr_r, last_r;
    logic [DATA_LEN-1:0] v_r;
    logic [15:0]         corr_r, uncorr_r;
    logic                rd_en_r, wr_en_r, busy_r, done_r;
    logic                rd_en_s, wr_en_s, busy_s, done_s;

    logic [DATA_LEN-1:0] a_s, b_s, c_s, v_s;
    logic                all_eq_s, any_pair_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    assign a_s        = mem_rdata[DATA_LEN-1:0];
    assign b_s        = mem_rdata[2*DATA_LEN-1:DATA_LEN];
    assign c_s        = mem_rdata[3*DATA_LEN-1:2*DATA_LEN];
    assign v_s        = (a_s & b_s) | (a_s & c_s) | (b_s & c_s);
    assign all_eq_s   = (a_s == b_s) && (b_s == c_s);
    assign any_pair_s = (a_s == b_s) || (a_s == c_s) || (b_s == c_s);

    // State and output registers; outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            rd_en_r <= 1'b0;
            wr_en_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            rd_en_r <= rd_en_s;
            wr_en_r <= wr_en_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic; abort out-ranks every other transition.
    always_comb begin
        state_s = state_r;
        if (abort && (state_r != IDLE)) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_s = start ? READ : IDLE;
                READ:    state_s = CHECK;
                CHECK:   state_s = (!all_eq_s && any_pair_s) ? WRITE : NEXT;
                WRITE:   state_s = NEXT;
                NEXT:    state_s = (addr_r == last_r) ? DONE : READ;
                DONE:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // Output decode of the upcoming state.
    always_comb begin
        rd_en_s = 1'b0;
        wr_en_s = 1'b0;
        done_s  = 1'b0;
        busy_s  = (state_s != IDLE);
        case (state_s)
            READ:    rd_en_s = 1'b1;
            WRITE:   wr_en_s = 1'b1;
            DONE:    done_s  = 1'b1;
            default: rd_en_s = 1'b0;
        endcase
    end

    // Address walker, voted word and outcome counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r   <= '0;
            last_r   <= '0;
            v_r      <= '0;
            corr_r   <= 16'd0;
            uncorr_r <= 16'd0;
        end else if ((state_r == IDLE) && start) begin
            addr_r   <= '0;
            last_r   <= last_addr;
            corr_r   <= 16'd0;
            uncorr_r <= 16'd0;
        end else if (!abort) begin
            case (state_r)
                CHECK: begin
                    v_r <= v_s;
                    if (!all_eq_s) begin
                        if (any_pair_s) begin
                            corr_r <= sat_inc(corr_r);
                        end else begin
                            uncorr_r <= sat_inc(uncorr_r);
                        end
                    end
                end
                NEXT: begin
                    if (addr_r != last_r) begin
                        addr_r <= addr_r + ADDR_W'(1);
                    end
                end
                default: addr_r <= addr_r;
            endcase
        end
    end

    assign mem_addr   = addr_r;
    assign mem_rd_en  = rd_en_r;
    assign mem_wr_en  = wr_en_r;
    assign mem_wdata  = {v_r, v_r, v_r};
    assign busy       = busy_r;
    assign done       = done_r;
    assign corr_cnt   = corr_r;
    assign uncorr_cnt = uncorr_r;

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Randomised self-checking bench for tmr_scrub_ctrl with a per-word
// classification model of the scrub pass and a behavioural memory.
module tb_tmr_scrub_ctrl;

    localparam int DL = 16;
    localparam int AW = 8;
    localparam int WW = 3 * DL;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [AW-1:0] last_addr, mem_addr;
    logic          mem_rd_en, mem_wr_en, busy, done;
    logic [WW-1:0] mem_rdata, mem_wdata;
    logic [15:0]   corr_cnt, uncorr_cnt;

    logic [WW-1:0] mem [256];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [WW-1:0] bd_data;

    int vectors = 0;
    int miscompares = 0;
    int n_rd = 0, n_wr = 0, n_done = 0;
    logic [AW+WW-1:0] wr_log[$];
    logic [AW+WW-1:0] exp_wr[$];

    always #5 clk = ~clk;

    tmr_scrub_ctrl #(.DATA_LEN(DL), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .last_addr(last_addr), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Synchronous-read memory with a backdoor load port.
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    // Bus monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_rd_en) n_rd <= n_rd + 1;
        if (mem_wr_en) begin
            n_wr <= n_wr + 1;
            wr_log.push_back({mem_addr, mem_wdata});
        end
        if (done) n_done <= n_done + 1;
        if (mem_rd_en && mem_wr_en) chk("rd_wr_excl", 64'd1, 64'd0);
    end

    task automatic poke(input int a, input logic [WW-1:0] d);
        bd_we = 1'b1; bd_addr = AW'(a); bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    function automatic logic [WW-1:0] gen_word(input int kind);
        logic [DL-1:0] a, b, c, m;
        a = DL'($urandom);
        m = DL'($urandom_range(1, 65535));
        case (kind)
            0: return {a, a, a};
            1: begin
                case ($urandom_range(0, 2))
                    0: return {a, a, a ^ m};
                    1: return {a, a ^ m, a};
                    default: return {a ^ m, a, a};
                endcase
            end
            default: begin
                b = a ^ m;
                do c = DL'($urandom); while (c == a || c == b);
                return {c, b, a};
            end
        endcase
    endfunction

    task automatic fill_random(input int last);
        for (int i = 0; i <= last; i++) poke(i, gen_word($urandom_range(0, 2)));
    endtask

    // Reference: classify each word by how many copies agree, bitwise vote.
    task automatic model_pass(input int last, output int lat, output int nc, output int nu);
        logic [DL-1:0] a, b, c, v;
        exp_wr.delete();
        lat = 0; nc = 0; nu = 0;
        for (int i = 0; i <= last; i++) begin
            a = mem[i][DL-1:0];
            b = mem[i][2*DL-1:DL];
            c = mem[i][3*DL-1:2*DL];
            for (int j = 0; j < DL; j++)
                v[j] = ((int'(a[j]) + int'(b[j]) + int'(c[j])) >= 2);
            if (a == b && b == c) begin
                lat += 3;
            end else if (a == b || a == c || b == c) begin
                lat += 4; nc++;
                exp_wr.push_back({AW'(i), v, v, v});
            end else begin
                lat += 3; nu++;
            end
        end
    endtask

    task automatic run_pass(input int last, input bit inject);
        int lat, nc, nu, k, r0, w0, d0, wl0;
        model_pass(last, lat, nc, nu);
        @(negedge clk);
        start = 1'b1; last_addr = AW'(last);
        @(posedge clk);
        r0 = n_rd; w0 = n_wr; d0 = n_done; wl0 = wr_log.size();
        k = 0;
        while (k < 3000) begin
            @(negedge clk);
            start = 1'b0;
            if (done) break;
            if (inject && lat > 8 && k == 5) begin
                start = 1'b1; last_addr = ~AW'(last);
            end
            @(posedge clk);
            k++;
        end
        chk("done_latency", 64'(k), 64'(lat));
        chk("busy_in_done", 64'(busy), 64'd1);
        chk("corr_cnt", 64'(corr_cnt), 64'(nc));
        chk("uncorr_cnt", 64'(uncorr_cnt), 64'(nu));
        chk("final_addr", 64'(mem_addr), 64'(last));
        @(posedge clk);
        chk("read_count", 64'(n_rd - r0), 64'(last + 1));
        chk("write_count", 64'(n_wr - w0), 64'(exp_wr.size()));
        chk("done_pulses", 64'(n_done - d0), 64'd1);
        for (int i = 0; i < exp_wr.size(); i++) begin
            if (wl0 + i < wr_log.size()) chk("write_word", 64'(wr_log[wl0 + i]), 64'(exp_wr[i]));
            else chk("write_missing", 64'd0, 64'(exp_wr[i]));
        end
        @(negedge clk);
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("done_single", 64'(done), 64'd0);
        chk("counters_hold", 64'({corr_cnt, uncorr_cnt}), 64'({16'(nc), 16'(nu)}));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_rd"}, 64'(mem_rd_en), 64'd0);
        chk({tag, "_wr"}, 64'(mem_wr_en), 64'd0);
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_corr"}, 64'(corr_cnt), 64'd0);
        chk({tag, "_uncorr"}, 64'(uncorr_cnt), 64'd0);
    endtask

    initial begin
        int k, w0, r0, d0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; last_addr = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // clean pass
        for (int i = 0; i < 4; i++) poke(i, {3{16'h1234}});
        run_pass(3, 1'b0);
        // single-copy error at addr1
        poke(1, {16'h1234, 16'h1234, 16'hFFFF});
        run_pass(3, 1'b0);
        // uncorrectable word at addr2
        poke(2, {16'h0001, 16'h0002, 16'h0004});
        run_pass(3, 1'b0);

        // abort during WRITE of addr1
        poke(1, {16'h1234, 16'h1234, 16'hFFFF});
        poke(2, {3{16'h1234}});
        @(negedge clk);
        start = 1'b1; last_addr = 8'd3;
        @(posedge clk);
        d0 = n_done;
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_wr_en) break;
            @(posedge clk);
            k++;
        end
        chk("abort_reach_write", 64'(mem_wr_en), 64'd1);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_rd", 64'(mem_rd_en), 64'd0);
        chk("abort_wr", 64'(mem_wr_en), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_corr_hold", 64'(corr_cnt), 64'd1);
        repeat (5) @(negedge clk);
        chk("abort_no_done", 64'(n_done - d0), 64'd0);
        chk("abort_stay_idle", 64'(busy), 64'd0);
        poke(3, {16'h0001, 16'h0002, 16'h0004});
        run_pass(3, 1'b0);

        // single-word pass
        poke(0, gen_word(1));
        run_pass(0, 1'b0);

        // full address space, with a start injected while busy
        fill_random(255);
        run_pass(255, 1'b1);

        // random short passes
        for (int t = 0; t < 3; t++) begin
            k = $urandom_range(1, 40);
            fill_random(k);
            run_pass(k, 1'b1);
        end

        // reset while CHECK holds a correctable word
        poke(0, {16'hAAAA, 16'h5555, 16'hAAAA});
        @(negedge clk);
        start = 1'b1; last_addr = 8'd3;
        @(posedge clk);
        w0 = n_wr;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        r0 = n_rd;
        repeat (6) @(negedge clk);
        @(posedge clk);
        chk("midrst_no_write", 64'(n_wr - w0), 64'd0);
        chk("midrst_no_read", 64'(n_rd - r0), 64'd0);
        chk("midrst_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
